// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: address/word widths,
// header field widths and the loader state encoding.
// Optional feature macro: LOADER_CHECKSUM_EN adds the trailing CHK byte state.
package loader_pkg;

  // Program counter / instruction memory address width
  localparam int D = 12;

  // Machine code word width
  localparam int W = 9;

  // Stream byte width
  localparam int BYTE_W = 8;

  // Word-count bits carried in the low nibble of HDR_HI; the upper nibble must be zero
  localparam int HDR_CNT_HI_W = 4;

  // Word bits carried in the HI byte; the remaining HI bits must be zero
  localparam int WORD_HI_W = W - BYTE_W;

  // Loader states; CHK only exists when the checksum feature is compiled in
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HDR_HI = 3'd1,
    S_HDR_LO = 3'd2,
    S_W_HI   = 3'd3,
    S_W_LO   = 3'd4,
`ifdef LOADER_CHECKSUM_EN
    S_CHK    = 3'd5,
`endif
    S_DONE   = 3'd6
  } state_e;

endpackage

// File: rtl/prog_loader_if.sv
// Bundle of the loader's host-side byte stream, instruction memory write
// port and status signals. The master modport is the host/stream side,
// the slave modport is the loader itself.
interface prog_loader_if #(
  parameter int D = loader_pkg::D,
  parameter int W = loader_pkg::W
);

  logic         load_req;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic         im_wr_en;
  logic [D-1:0] im_addr;
  logic [W-1:0] im_wr_data;
  logic         start;
  logic         busy;
  logic         err;

  // Host view: drives the request and byte stream, observes everything else
  modport master (
    output load_req, in_valid, in_data,
    input  in_ready, im_wr_en, im_addr, im_wr_data, start, busy, err
  );

  // Loader view: consumes the byte stream, drives memory writes and status
  modport slave (
    input  load_req, in_valid, in_data,
    output in_ready, im_wr_en, im_addr, im_wr_data, start, busy, err
  );

endinterface

// File: rtl/loader_chk.sv
// Running XOR of the payload bytes of one load session. Cleared when a new
// session starts, updated on every accepted word byte.
// Only instantiated when LOADER_CHECKSUM_EN is defined.
module loader_chk #(
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          en_i,
  input  logic [BW-1:0] data_i,
  output logic [BW-1:0] acc_o
);

  logic [BW-1:0] acc_q, acc_d;

  // Clear wins over accumulate so a new session always starts from zero
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q ^ data_i;
    end
  end

  // Accumulator register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/prog_loader.sv
// Program loader: receives a byte stream (header with word count, then
// HI/LO byte pairs per instruction word) and writes the words into the
// instruction memory from address 0, then pulses start to release the
// processor. Malformed bytes set a sticky err and abandon the session.
// Optional feature macro: LOADER_CHECKSUM_EN expects a trailing XOR
// checksum byte over all word bytes; a mismatch sets err and blocks start.
module prog_loader #(
  parameter int D = loader_pkg::D,
  parameter int W = loader_pkg::W
) (
  input logic         clk,
  input logic         rst_n,
  prog_loader_if.slave bus
);

  import loader_pkg::*;

  // Where the stream goes after the last word (or an empty header)
`ifdef LOADER_CHECKSUM_EN
  localparam state_e S_AFTER_WORDS = S_CHK;
`else
  localparam state_e S_AFTER_WORDS = S_DONE;
`endif

  state_e                  state_q, state_d;
  logic [HDR_CNT_HI_W-1:0] hdrCnt_q, hdrCnt_d;
  logic [D-1:0]            count_q, count_d;
  logic [D-1:0]            word_q, word_d;
  logic [D-1:0]            addr_q, addr_d;
  logic [WORD_HI_W-1:0]    hiBits_q, hiBits_d;
  logic                    wrEn_q, wrEn_d;
  logic [W-1:0]            wrData_q, wrData_d;
  logic                    err_q, err_d;
  logic                    inReady;
  logic                    xfer;
  logic [D-1:0]            hdrCount;
  logic [D-1:0]            wordNext;

`ifdef LOADER_CHECKSUM_EN
  logic                    chkClear;
  logic                    chkEn;
  logic [BYTE_W-1:0]       chkAcc;

  // Payload checksum accumulator
  loader_chk #(.BW(BYTE_W)) u_chk (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear_i(chkClear),
    .en_i   (chkEn),
    .data_i (bus.in_data),
    .acc_o  (chkAcc)
  );
`endif

  assign xfer     = bus.in_valid & inReady;
  assign hdrCount = D'({hdrCnt_q, bus.in_data});
  assign wordNext = word_q + D'(1);

  // Next-state and datapath decode; every byte-driven move waits for a transfer
  always_comb begin
    state_d  = state_q;
    hdrCnt_d = hdrCnt_q;
    count_d  = count_q;
    word_d   = word_q;
    addr_d   = addr_q;
    hiBits_d = hiBits_q;
    wrEn_d   = 1'b0;
    wrData_d = wrData_q;
    err_d    = err_q;
    inReady  = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    chkClear = 1'b0;
    chkEn    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.load_req) begin
          state_d = S_HDR_HI;
          err_d   = 1'b0;
          word_d  = '0;
          count_d = '0;
`ifdef LOADER_CHECKSUM_EN
          chkClear = 1'b1;
`endif
        end
      end
      S_HDR_HI: begin
        inReady = 1'b1;
        if (xfer) begin
          if (bus.in_data[BYTE_W-1:HDR_CNT_HI_W] != '0) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            hdrCnt_d = bus.in_data[HDR_CNT_HI_W-1:0];
            state_d  = S_HDR_LO;
          end
        end
      end
      S_HDR_LO: begin
        inReady = 1'b1;
        if (xfer) begin
          count_d = hdrCount;
          state_d = (hdrCount == '0) ? S_AFTER_WORDS : S_W_HI;
        end
      end
      S_W_HI: begin
        inReady = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        chkEn = xfer;
`endif
        if (xfer) begin
          if (bus.in_data[BYTE_W-1:WORD_HI_W] != '0) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            hiBits_d = bus.in_data[WORD_HI_W-1:0];
            state_d  = S_W_LO;
          end
        end
      end
      S_W_LO: begin
        inReady = 1'b1;
`ifdef LOADER_CHECKSUM_EN
        chkEn = xfer;
`endif
        if (xfer) begin
          wrEn_d   = 1'b1;
          wrData_d = {hiBits_q, bus.in_data};
          addr_d   = word_q;
          word_d   = wordNext;
          state_d  = (wordNext == count_q) ? S_AFTER_WORDS : S_W_HI;
        end
      end
`ifdef LOADER_CHECKSUM_EN
      S_CHK: begin
        inReady = 1'b1;
        if (xfer) begin
          if (bus.in_data != chkAcc) begin
            err_d = 1'b1;
          end
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset abandons any session in progress
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Header, counters, write port and error flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdrCnt_q <= '0;
      count_q  <= '0;
      word_q   <= '0;
      addr_q   <= '0;
      hiBits_q <= '0;
      wrEn_q   <= 1'b0;
      wrData_q <= '0;
      err_q    <= 1'b0;
    end else begin
      hdrCnt_q <= hdrCnt_d;
      count_q  <= count_d;
      word_q   <= word_d;
      addr_q   <= addr_d;
      hiBits_q <= hiBits_d;
      wrEn_q   <= wrEn_d;
      wrData_q <= wrData_d;
      err_q    <= err_d;
    end
  end

  assign bus.in_ready   = inReady;
  assign bus.im_wr_en   = wrEn_q;
  assign bus.im_addr    = addr_q;
  assign bus.im_wr_data = wrData_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.start      = (state_q == S_DONE) && !err_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: a cycle-by-cycle vector table for a
// three-word load, then hand-written sequences for throttled input, empty
// and malformed streams, checksum handling and mid-session reset.
// Honours LOADER_CHECKSUM_EN to match the build under test.
module tb_prog_loader;

  logic clk = 1'b0;
  logic rst_n;

  int passChecks  = 0;
  int totalChecks = 0;

  prog_loader_if #(.D(12), .W(9)) bus ();

  prog_loader #(.D(12), .W(9)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // 100 MHz-style free-running clock
  always #5 clk = ~clk;

  typedef struct {
    logic       loadReq;
    logic       inValid;
    logic [7:0] inData;
    logic       expReady;
    logic       expWrEn;
    logic [11:0] expAddr;
    logic [8:0] expData;
    logic       expStart;
    logic       expBusy;
    logic       expErr;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] streamBytes[$];
  logic [8:0] expWords[$];
  logic [11:0] wrAddrLog[$];
  logic [8:0] wrDataLog[$];
  int         startCount = 0;

  // Record every memory write and start pulse, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.im_wr_en === 1'b1) begin
      wrAddrLog.push_back(bus.im_addr);
      wrDataLog.push_back(bus.im_wr_data);
    end
    if (bus.start === 1'b1) begin
      startCount = startCount + 1;
    end
  end

  // Hard stop in case anything stalls
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Drive one cycle of inputs and land just after the rising edge
  task automatic applyStimulus(input logic lr, input logic v, input logic [7:0] d);
    bus.load_req = lr;
    bus.in_valid = v;
    bus.in_data  = d;
    @(posedge clk);
    #1;
  endtask

  // Single comparison with bookkeeping
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalChecks = totalChecks + 1;
    if (act === exp) begin
      passChecks = passChecks + 1;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic lr, input logic v, input logic [7:0] d,
                        input logic rdy, input logic wr, input logic [11:0] a,
                        input logic [8:0] wd, input logic st, input logic bsy,
                        input logic er);
    vec_t x;
    x.loadReq = lr; x.inValid = v; x.inData = d;
    x.expReady = rdy; x.expWrEn = wr; x.expAddr = a; x.expData = wd;
    x.expStart = st; x.expBusy = bsy; x.expErr = er;
    vecs.push_back(x);
  endtask

  task automatic clearLog();
    wrAddrLog.delete();
    wrDataLog.delete();
    startCount = 0;
  endtask

  // Load request, then each stream byte (optionally with an idle cycle before it)
  task automatic sendStream(input bit toggle);
    applyStimulus(1'b1, 1'b0, 8'h00);
    foreach (streamBytes[i]) begin
      if (toggle) applyStimulus(1'b0, 1'b0, 8'hEE);
      applyStimulus(1'b0, 1'b1, streamBytes[i]);
    end
    applyStimulus(1'b0, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
  endtask

  // Compare logged writes with expWords at addresses 0..N-1
  task automatic checkWrites(input string name);
    int n;
    checkOutput({name, "_count"}, wrAddrLog.size(), expWords.size());
    n = (wrAddrLog.size() < expWords.size()) ? wrAddrLog.size() : expWords.size();
    for (int i = 0; i < n; i++) begin
      checkOutput($sformatf("%s_addr%0d", name, i), wrAddrLog[i], i);
      checkOutput($sformatf("%s_data%0d", name, i), wrDataLog[i], expWords[i]);
    end
  endtask

  task automatic loadThreeWordStream();
    streamBytes = '{8'h00, 8'h03, 8'h01, 8'hA5, 8'h00, 8'h33, 8'h01, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    streamBytes.push_back(8'h96);
`endif
    expWords = '{9'h1A5, 9'h033, 9'h100};
  endtask

  // Main test sequence
  initial begin
    logic [31:0] act;
    logic [31:0] exp;

    rst_n        = 1'b0;
    bus.load_req = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    checkOutput("reset_outputs",
                {bus.in_ready, bus.im_wr_en, bus.start, bus.busy, bus.err, bus.im_addr, bus.im_wr_data},
                32'h0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);

    // Vector table: three-word load with continuous valid
    //     lr  v   data   rdy wr  addr    data    st  bsy err
    addVec(1, 0, 8'h00,  1,  0, 12'd0, 9'h000, 0, 1, 0);
    addVec(0, 1, 8'h00,  1,  0, 12'd0, 9'h000, 0, 1, 0);
    addVec(0, 1, 8'h03,  1,  0, 12'd0, 9'h000, 0, 1, 0);
    addVec(0, 1, 8'h01,  1,  0, 12'd0, 9'h000, 0, 1, 0);
    addVec(0, 1, 8'hA5,  1,  1, 12'd0, 9'h1A5, 0, 1, 0);
    addVec(0, 1, 8'h00,  1,  0, 12'd0, 9'h000, 0, 1, 0);
    addVec(0, 1, 8'h33,  1,  1, 12'd1, 9'h033, 0, 1, 0);
    addVec(0, 1, 8'h01,  1,  0, 12'd0, 9'h000, 0, 1, 0);
`ifdef LOADER_CHECKSUM_EN
    addVec(0, 1, 8'h00,  1,  1, 12'd2, 9'h100, 0, 1, 0);
    addVec(0, 1, 8'h96,  0,  0, 12'd0, 9'h000, 1, 1, 0);
`else
    addVec(0, 1, 8'h00,  0,  1, 12'd2, 9'h100, 1, 1, 0);
`endif
    addVec(0, 0, 8'h00,  0,  0, 12'd0, 9'h000, 0, 0, 0);
    addVec(0, 1, 8'h55,  0,  0, 12'd0, 9'h000, 0, 0, 0);
    addVec(0, 1, 8'h01,  0,  0, 12'd0, 9'h000, 0, 0, 0);

    clearLog();
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].loadReq, vecs[i].inValid, vecs[i].inData);
      act = {6'b0, bus.in_ready, bus.im_wr_en, bus.start, bus.busy, bus.err,
             vecs[i].expWrEn ? bus.im_addr : 12'h0,
             vecs[i].expWrEn ? bus.im_wr_data : 9'h0};
      exp = {6'b0, vecs[i].expReady, vecs[i].expWrEn, vecs[i].expStart, vecs[i].expBusy,
             vecs[i].expErr, vecs[i].expAddr, vecs[i].expData};
      checkOutput($sformatf("vec%0d", i), act, exp);
    end
    loadThreeWordStream();
    checkWrites("table");
    checkOutput("table_starts", startCount, 1);

    // Same stream with valid toggling every other cycle
    clearLog();
    loadThreeWordStream();
    sendStream(1'b1);
    checkWrites("toggle");
    checkOutput("toggle_starts", startCount, 1);
    checkOutput("toggle_err", bus.err, 0);

    // Bad HI byte on word 1: one write, err, back to idle, trailing bytes ignored
    clearLog();
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h03);
    applyStimulus(1'b0, 1'b1, 8'h01);
    applyStimulus(1'b0, 1'b1, 8'hA5);
    applyStimulus(1'b0, 1'b1, 8'h02);
    checkOutput("badhi_err_now", bus.err, 1);
    applyStimulus(1'b0, 1'b1, 8'h33);
    checkOutput("badhi_busy_2cyc", {bus.busy, bus.in_ready}, 2'b00);
    applyStimulus(1'b0, 1'b1, 8'h01);
    applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    expWords = '{9'h1A5};
    checkWrites("badhi");
    checkOutput("badhi_starts", startCount, 0);
    checkOutput("badhi_err_sticky", bus.err, 1);

    // Empty image; also clears the error left by the previous session
    clearLog();
    streamBytes = '{8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
    streamBytes.push_back(8'h00);
`endif
    expWords.delete();
    sendStream(1'b0);
    checkWrites("empty");
    checkOutput("empty_starts", startCount, 1);
    checkOutput("empty_err", bus.err, 0);

    // Nonzero reserved nibble in HDR_HI
    clearLog();
    streamBytes = '{8'h10, 8'h01, 8'h00, 8'h11};
    sendStream(1'b0);
    checkWrites("badhdr");
    checkOutput("badhdr_starts", startCount, 0);
    checkOutput("badhdr_err", {bus.err, bus.busy}, 2'b10);

`ifdef LOADER_CHECKSUM_EN
    // Single word 0x0FF with wrong then correct checksum
    clearLog();
    streamBytes = '{8'h00, 8'h01, 8'h00, 8'hFF, 8'h00};
    expWords = '{9'h0FF};
    sendStream(1'b0);
    checkWrites("chkbad");
    checkOutput("chkbad_starts", startCount, 0);
    checkOutput("chkbad_err", bus.err, 1);
    clearLog();
    streamBytes = '{8'h00, 8'h01, 8'h00, 8'hFF, 8'hFF};
    sendStream(1'b0);
    checkWrites("chkgood");
    checkOutput("chkgood_starts", startCount, 1);
    checkOutput("chkgood_err", bus.err, 0);
`endif

    // Reset asserted mid-session during W_LO of word 5
    clearLog();
    applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h00);
    applyStimulus(1'b0, 1'b1, 8'h06);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 1'b1, 8'h00);
      applyStimulus(1'b0, 1'b1, 8'(k + 3));
    end
    applyStimulus(1'b0, 1'b1, 8'h01);
    checkOutput("prereset_busy", {bus.busy, bus.im_addr}, {1'b1, 12'd4});
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset_outputs",
                {bus.in_ready, bus.im_wr_en, bus.start, bus.busy, bus.err, bus.im_addr, bus.im_wr_data},
                32'h0);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    clearLog();
    loadThreeWordStream();
    sendStream(1'b0);
    checkWrites("postreset");
    checkOutput("postreset_starts", startCount, 1);
    checkOutput("postreset_err", bus.err, 0);

    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter D, 12, program counter / instruction memory address width.
REQ-002 Parameter W, 9, machine code word width.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 load_req  input  1  begins a load session when sampled high in IDLE.
REQ-006 in_valid  input  1  byte stream valid.
REQ-007 in_data  input  8  byte stream data.
REQ-008 in_ready  output  1  loader accepts byte; transfer = in_valid & in_ready on a clk edge.
REQ-009 im_wr_en  output  1  instruction memory write strobe.
REQ-010 im_addr  output  D  instruction memory write address.
REQ-011 im_wr_data  output  W  instruction word to write.
REQ-012 start  output  1  one-cycle pulse releasing the processor after a good load.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 err  output  1  sticky error flag, cleared by the next accepted load_req.

Function
REQ-015 Stream format SHALL be: HDR_HI, HDR_LO, then N word pairs (HI, LO), then CHK byte when checksum is compiled in; N = {HDR_HI[3:0], HDR_LO}, range 0..4095.
REQ-016 Word k SHALL be im_wr_data = {HI[0], LO}, written to im_addr = k, k = 0..N-1.
REQ-017 States SHALL be IDLE, HDR_HI, HDR_LO, W_HI, W_LO, CHK, DONE; transitions occur only on accepted bytes, except IDLE->HDR_HI on load_req and DONE->IDLE unconditionally.
REQ-018 in_ready SHALL be high in HDR_HI, HDR_LO, W_HI, W_LO, CHK and low in IDLE and DONE.
REQ-019 im_wr_en SHALL pulse for exactly one cycle, the cycle after the LO byte transfer, with im_addr/im_wr_data stable during that cycle; the next HI byte may be accepted in the same cycle.
REQ-020 Word address counter SHALL increment after each write and never wrap within a session.
REQ-021 N = 0 SHALL skip W_HI/W_LO, perform no writes, and proceed to CHK (or DONE).
REQ-022 HDR_HI[7:4] != 0 or HI[7:1] != 0 SHALL set err and return to IDLE the next cycle with no further writes; start SHALL not pulse.
REQ-023 start SHALL pulse in DONE, one cycle after the last byte (LO or CHK) transfer, only if err is clear.
REQ-024 load_req while busy SHALL be ignored; in_valid in IDLE SHALL be ignored (no transfer).

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE, counters 0, in_ready/im_wr_en/start/busy/err 0, im_addr 0, im_wr_data 0, including mid-session; a partially loaded image is abandoned.

Configuration
REQ-026 With LOADER_CHECKSUM_EN defined, SHALL XOR all bytes after HDR_LO into an 8-bit accumulator (cleared on load_req), expect CHK equal to it, and on mismatch set err and suppress start.
REQ-027 Without LOADER_CHECKSUM_EN, CHK state and accumulator SHALL be absent; W_LO of the last word (or HDR_LO when N = 0) goes directly to DONE.

Structure
REQ-028 Package loader_pkg SHALL hold the state enum, D, W and header field widths.
REQ-029 The checksum accumulator SHALL be sub-module loader_chk, instantiated only under LOADER_CHECKSUM_EN.

Verification
REQ-030 N=3, words 0x1A5,0x033,0x100, continuous in_valid -> writes addr 0,1,2 with those values, start pulse once, err 0.
REQ-031 Same stream with in_valid toggling every other cycle -> identical writes and order; no duplicate or missing im_wr_en.
REQ-032 Header 0x00,0x00 (plus CHK 0x00 if enabled) -> zero writes, start pulse, err 0.
REQ-033 HI byte 0x02 on word 1 -> err 1, one write only (addr 0), no start, busy 0 two cycles later.
REQ-034 (LOADER_CHECKSUM_EN) N=1 word 0x0FF with CHK 0x00 vs correct 0xFF -> err 1/no start vs err 0/start.
REQ-035 rst_n low during W_LO of word 5 -> all outputs 0 immediately; new load_req then loads correctly from addr 0.
